// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced three-press operand capture and result latch for a 4-bit ALU
module alu_operand_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] sw_val,
    input  logic       sw_sub,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_sub,
    input  logic [3:0] alu_result,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [3:0] res_q,
    output logic       ovf_q,
    output logic       zero_q,
    output logic       carry_q,
    output logic       res_valid,
    output logic [1:0] state_q,
    output logic [7:0] op_count
);
    typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_EXEC = 2'd2, S_SHOW = 2'd3} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_sync;
    logic        r_deb, r_deb_d, r_press;
    logic [15:0] r_cnt;
    logic        w_btn_s, w_diff, w_done;
    assign w_btn_s = r_sync[1];
    assign w_diff  = w_btn_s != r_deb;
    assign w_done  = r_cnt == DEBOUNCE_CYCLES - 16'd1;
    assign state_q = r_state;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_cnt   <= (!w_diff || w_done) ? '0 : r_cnt + 16'd1;
            r_deb   <= (w_diff && w_done) ? w_btn_s : r_deb;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
        end
    end
    // EXEC is a single unconditional cycle; a press landing there is dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_A:     if (r_press) w_next = S_B;
            S_B:     if (r_press) w_next = S_EXEC;
            S_EXEC:  w_next = S_SHOW;
            default: if (r_press) w_next = S_A;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_A;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sub   <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_press && r_state == S_A) alu_a <= sw_val;
            if (r_press && r_state == S_B) begin
                alu_b   <= sw_val;
                alu_sub <= sw_sub;
            end
            if (r_state == S_EXEC) begin
                res_q     <= alu_result;
                ovf_q     <= alu_overflow;
                zero_q    <= alu_zero;
                carry_q   <= alu_carry;
                res_valid <= 1'b1;
                op_count  <= op_count + 8'd1;
            end
            if (r_press && r_state == S_SHOW) res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed vectors and press sequences against a 4-bit ALU model
module tb_alu_operand_sequencer;
    logic       clk = 1'b0, rst = 1'b1, btn = 1'b0, sw_sub = 1'b0;
    logic [3:0] sw_val = '0;
    logic [3:0] alu_a, alu_b, alu_result, res_q;
    logic       alu_sub, alu_overflow, alu_zero, alu_carry;
    logic       ovf_q, zero_q, carry_q, res_valid;
    logic [1:0] state_q;
    logic [7:0] op_count;
    logic [3:0] w_bb;
    logic [4:0] w_sum;
    int n_vec = 0, n_bad = 0, press_cnt = 0;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw_val(sw_val), .sw_sub(sw_sub),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .res_q(res_q), .ovf_q(ovf_q), .zero_q(zero_q), .carry_q(carry_q),
        .res_valid(res_valid), .state_q(state_q), .op_count(op_count)
    );

    // reference two's-complement add/subtract unit fed by the registered operands
    assign w_bb         = alu_sub ? ~alu_b : alu_b;
    assign w_sum        = {1'b0, alu_a} + {1'b0, w_bb} + {4'd0, alu_sub};
    assign alu_result   = w_sum[3:0];
    assign alu_carry    = w_sum[4];
    assign alu_zero     = w_sum[3:0] == 4'd0;
    assign alu_overflow = (alu_a[3] == w_bb[3]) && (w_sum[3] != alu_a[3]);

    always #5 clk = ~clk;
    always @(posedge clk) if (dut.r_press) press_cnt = press_cnt + 1;

    typedef struct {
        logic [3:0] a, b;
        logic       sub;
        logic [3:0] res;
        logic       ovf, zero, carry;
    } vec_t;
    vec_t v[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(output int lat);
        lat = -1;
        btn = 1'b1;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(negedge clk);
            if (dut.r_press) lat = k;
        end
        if (lat < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL press_timeout: got no press expected press within 30 cycles");
        end
    endtask

    task automatic release_btn;
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seq;
        int lat;
        repeat (3) begin
            press(lat);
            @(negedge clk);
            release_btn();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, p0;
        v[0] = '{4'd3, 4'd5, 1'b0, 4'd8,  1'b1, 1'b0, 1'b0};
        v[1] = '{4'd7, 4'd7, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1};
        v[2] = '{4'd15, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        v[3] = '{4'd2, 4'd5, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0};
        v[4] = '{4'd8, 4'd1, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1};
        v[5] = '{4'd9, 4'd6, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        do_reset();
        chk("rst_state", state_q, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_res_q", res_q, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_count", op_count, 0);
        // bouncy press then bouncy release
        p0 = press_cnt;
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0);
            @(negedge clk);
        end
        btn = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dut.r_press && lat < 0) lat = k;
        end
        chk("bounce_presses", press_cnt - p0, 1);
        chk("bounce_latency", lat, 7);
        chk("bounce_state", state_q, 1);
        p0 = press_cnt;
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 1);
            @(negedge clk);
        end
        btn = 1'b0;
        repeat (20) @(negedge clk);
        chk("release_presses", press_cnt - p0, 0);
        chk("release_deb", dut.r_deb, 0);
        chk("release_state", state_q, 1);
        do_reset();
        // table-driven full sequences
        for (int i = 0; i < 6; i++) begin
            sw_val = v[i].a;
            sw_sub = ~v[i].sub;
            press(lat);
            chk("lat", lat, 7);
            @(negedge clk);
            chk("state_b", state_q, 1);
            chk("alu_a", alu_a, v[i].a);
            release_btn();
            sw_val = v[i].b;
            sw_sub = v[i].sub;
            press(lat);
            @(negedge clk);
            chk("state_exec", state_q, 2);
            chk("valid_exec", res_valid, 0);
            @(negedge clk);
            chk("state_show", state_q, 3);
            chk("alu_a_held", alu_a, v[i].a);
            chk("alu_b", alu_b, v[i].b);
            chk("alu_sub", alu_sub, v[i].sub);
            chk("res_q", res_q, v[i].res);
            chk("ovf_q", ovf_q, v[i].ovf);
            chk("zero_q", zero_q, v[i].zero);
            chk("carry_q", carry_q, v[i].carry);
            chk("res_valid", res_valid, 1);
            chk("op_count", op_count, i + 1);
            release_btn();
            sw_val = ~v[i].b;
            sw_sub = ~v[i].sub;
            repeat (3) @(negedge clk);
            chk("show_res_held", res_q, v[i].res);
            chk("show_b_held", alu_b, v[i].b);
            chk("show_sub_held", alu_sub, v[i].sub);
            press(lat);
            @(negedge clk);
            chk("back_state", state_q, 0);
            chk("back_valid", res_valid, 0);
            chk("back_res_held", res_q, v[i].res);
            release_btn();
        end
        // reset while in S_B with the debounce counter running
        sw_val = 4'd9;
        press(lat);
        @(negedge clk);
        release_btn();
        chk("mid_alu_a", alu_a, 9);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_state", state_q, 0);
        chk("mid_alu_a_clr", alu_a, 0);
        chk("mid_count", op_count, 0);
        chk("mid_valid", res_valid, 0);
        chk("mid_cnt", dut.r_cnt, 0);
        chk("mid_deb", dut.r_deb, 0);
        // button held through reset release
        sw_val = 4'd6;
        @(negedge clk);
        p0 = press_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_presses", press_cnt - p0, 1);
        chk("held_state", state_q, 1);
        chk("held_alu_a", alu_a, 6);
        release_btn();
        // op_count wrap
        do_reset();
        repeat (256) run_seq();
        chk("wrap_256", op_count, 0);
        run_seq();
        chk("wrap_257", op_count, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
